// File: rtl/ip_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module : ip_rx_pkg
// Brief  : Shared constants for the IP receive dispatcher (state encoding,
//          protocol numbers, default counter width).
// Rev    : 1.0
// ============================================================================
package ip_rx_pkg;

  localparam int CNT_W_DEFAULT = 16;

  localparam logic [7:0] PROTO_ICMP = 8'd1;
  localparam logic [7:0] PROTO_UDP  = 8'd17;

  localparam logic [3:0] ST_IDLE = 4'b0001;
  localparam logic [3:0] ST_ICMP = 4'b0010;
  localparam logic [3:0] ST_UDP  = 4'b0100;
  localparam logic [3:0] ST_DROP = 4'b1000;

  function automatic logic addr_match(input logic        bcast,
                                      input logic [31:0] to_ip,
                                      input logic [31:0] my_ip);
    return bcast | (to_ip == my_ip);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module : sat_counter
// Brief  : Enabled up-counter that saturates at all-ones; async active-low clear.
// Rev    : 1.0
// ============================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/ip_rx_dispatch.sv
`default_nettype none
// ============================================================================
// Module : ip_rx_dispatch
// Brief  : Routes IP payload bytes to the ICMP or UDP sink, or drops the packet.
//          Statistics counters present only when IP_RX_DISPATCH_STATS_EN is defined.
// Rev    : 1.0
// ============================================================================
module ip_rx_dispatch
  import ip_rx_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_enable,
  input  logic [7:0]       data,
  input  logic             ip_active,
  input  logic             ip_is_icmp,
  input  logic             ip_broadcast,
  input  logic [31:0]      ip_to_ip,
  input  logic [31:0]      ip_remote_ip,
  input  logic [31:0]      local_ip,
  input  logic             icmp_ready,
  input  logic             udp_ready,
  output logic             icmp_rx_enable,
  output logic             udp_rx_enable,
  output logic [7:0]       data_out,
  output logic [31:0]      remote_ip_out,
  output logic [CNT_W-1:0] accept_count,
  output logic [CNT_W-1:0] drop_count
);

  logic [3:0]  state_q, state_d;
  logic        armed_q, armed_d;
  logic [7:0]  data_q;
  logic [31:0] remote_q, remote_d;

  logic decide;
  logic to_icmp;
  logic to_udp;
  logic accepted;

  // armed_q blocks a decision on a packet already in flight when reset lifted.
  assign decide   = (state_q == ST_IDLE) & armed_q & rx_enable & ip_active;
  assign to_icmp  = addr_match(ip_broadcast, ip_to_ip, local_ip) & ip_is_icmp & icmp_ready;
  assign to_udp   = addr_match(ip_broadcast, ip_to_ip, local_ip) & ~ip_is_icmp & udp_ready;
  assign accepted = to_icmp | to_udp;

  always_comb begin
    state_d  = state_q;
    armed_d  = armed_q | ~ip_active;
    remote_d = remote_q;
    if (!rx_enable) begin
      state_d = ST_IDLE;
    end else if (decide) begin
      armed_d = 1'b0;
      if (to_icmp) begin
        state_d = ST_ICMP;
      end else if (to_udp) begin
        state_d = ST_UDP;
      end else begin
        state_d = ST_DROP;
      end
      if (accepted) begin
        remote_d = ip_remote_ip;
      end
    end else if ((state_q != ST_IDLE) && !ip_active) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      armed_q  <= 1'b0;
      data_q   <= 8'h00;
      remote_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      armed_q  <= armed_d;
      data_q   <= data;
      remote_q <= remote_d;
    end
  end

  // Forwarding states are only entered/held while a payload byte is present,
  // so the state itself is the one-cycle-delayed byte qualifier.
  assign icmp_rx_enable = (state_q == ST_ICMP);
  assign udp_rx_enable  = (state_q == ST_UDP);
  assign data_out       = data_q;
  assign remote_ip_out  = remote_q;

`ifdef IP_RX_DISPATCH_STATS_EN
  logic accept_inc;
  logic drop_inc;

  assign accept_inc = decide & accepted;
  assign drop_inc   = decide & ~accepted;

  sat_counter #(.W(CNT_W)) u_accept_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accept_inc),
    .count (accept_count)
  );

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (drop_inc),
    .count (drop_count)
  );
`else
  assign accept_count = '0;
  assign drop_count   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ip_rx_dispatch.sv
`default_nettype none
// ============================================================================
// Module : tb_ip_rx_dispatch
// Brief  : Directed packet bench with a packet-level reference model.
// Rev    : 1.0
// ============================================================================
module tb_ip_rx_dispatch;

`ifdef IP_RX_DISPATCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [31:0] LOCAL = 32'hC0A8010A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_enable = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        ip_active = 1'b0;
  logic        ip_is_icmp = 1'b0;
  logic        ip_broadcast = 1'b0;
  logic [31:0] ip_to_ip = 32'h0;
  logic [31:0] ip_remote_ip = 32'h0;
  logic        icmp_ready = 1'b0;
  logic        udp_ready = 1'b0;

  logic        icmp_en, udp_en, icmp_en_s, udp_en_s;
  logic [7:0]  dout, dout_s;
  logic [31:0] rip, rip_s;
  logic [15:0] acc_cnt, drp_cnt;
  logic [1:0]  acc_s, drp_s;

  ip_rx_dispatch #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .rx_enable(rx_enable), .data(data),
    .ip_active(ip_active), .ip_is_icmp(ip_is_icmp), .ip_broadcast(ip_broadcast),
    .ip_to_ip(ip_to_ip), .ip_remote_ip(ip_remote_ip), .local_ip(LOCAL),
    .icmp_ready(icmp_ready), .udp_ready(udp_ready),
    .icmp_rx_enable(icmp_en), .udp_rx_enable(udp_en), .data_out(dout),
    .remote_ip_out(rip), .accept_count(acc_cnt), .drop_count(drp_cnt)
  );

  // Narrow-counter instance so saturation is reachable in a short run.
  ip_rx_dispatch #(.CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .rx_enable(rx_enable), .data(data),
    .ip_active(ip_active), .ip_is_icmp(ip_is_icmp), .ip_broadcast(ip_broadcast),
    .ip_to_ip(ip_to_ip), .ip_remote_ip(ip_remote_ip), .local_ip(LOCAL),
    .icmp_ready(icmp_ready), .udp_ready(udp_ready),
    .icmp_rx_enable(icmp_en_s), .udp_rx_enable(udp_en_s), .data_out(dout_s),
    .remote_ip_out(rip_s), .accept_count(acc_s), .drop_count(drp_s)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level model state
  int          m_acc = 0;
  int          m_drp = 0;
  logic [31:0] m_rem = 32'h0;

  logic        pend_icmp = 0, pend_udp = 0;
  logic [7:0]  pend_data = 0;
  logic [31:0] pend_rem = 0, pend_acc = 0, pend_drp = 0, pend_acc_s = 0, pend_drp_s = 0;
  logic        exp_icmp = 0, exp_udp = 0;
  logic [7:0]  exp_data = 0;
  logic [31:0] exp_rem = 0, exp_acc = 0, exp_drp = 0, exp_acc_s = 0, exp_drp_s = 0;
  bit          chk_en = 1'b0;

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic model_counts();
    pend_rem   = m_rem;
    pend_acc   = STATS ? m_acc : 0;
    pend_drp   = STATS ? m_drp : 0;
    pend_acc_s = STATS ? sat3(m_acc) : 0;
    pend_drp_s = STATS ? sat3(m_drp) : 0;
  endtask

  always @(posedge clk) begin
    exp_icmp  <= pend_icmp;  exp_udp  <= pend_udp;  exp_data  <= pend_data;
    exp_rem   <= pend_rem;   exp_acc  <= pend_acc;  exp_drp   <= pend_drp;
    exp_acc_s <= pend_acc_s; exp_drp_s <= pend_drp_s;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("icmp_rx_enable", {31'b0, icmp_en}, {31'b0, exp_icmp});
      chk("udp_rx_enable",  {31'b0, udp_en},  {31'b0, exp_udp});
      chk("data_out",       {24'b0, dout},    {24'b0, exp_data});
      chk("remote_ip_out",  rip,              exp_rem);
      chk("accept_count",   {16'b0, acc_cnt}, exp_acc);
      chk("drop_count",     {16'b0, drp_cnt}, exp_drp);
      chk("narrow_accept",  {30'b0, acc_s},   exp_acc_s);
      chk("narrow_drop",    {30'b0, drp_s},   exp_drp_s);
      chk("narrow_enables", {30'b0, icmp_en_s, udp_en_s}, {30'b0, exp_icmp, exp_udp});
    end
  end

  // Non-payload cycles: between frames (frame=0) or header bytes (frame=1).
  task automatic idle(input int n, input bit frame);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      rx_enable = frame;
      ip_active = 1'b0;
      data      = 8'($urandom);
      pend_icmp = 1'b0; pend_udp = 1'b0; pend_data = data;
      model_counts();
    end
  endtask

  task automatic send_pkt(input logic [31:0] to, input logic [31:0] rem,
                          input bit icmp, input bit bc, input bit ir, input bit ur,
                          input int n, input int chg_at, input int abort_at,
                          input int rst_at);
    int  kind;
    bit  blocked;
    blocked = 1'b0;
    kind = 0;
    if ((bc || to == LOCAL) && (icmp ? ir : ur)) kind = icmp ? 1 : 2;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      if (i == abort_at) begin
        rx_enable = 1'b0;
        ip_active = 1'b1;
        data      = 8'hEE;
        pend_icmp = 1'b0; pend_udp = 1'b0; pend_data = data;
        model_counts();
        break;
      end
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_icmp_en", {31'b0, icmp_en}, 32'h0);
        chk("rst_data_out", {24'b0, dout}, 32'h0);
        chk("rst_remote", rip, 32'h0);
        chk("rst_acc", {16'b0, acc_cnt}, 32'h0);
        m_acc = 0; m_drp = 0; m_rem = 32'h0;
        blocked = 1'b1;
        rst_n = 1'b1;
      end
      rx_enable    = 1'b1;
      ip_active    = 1'b1;
      ip_is_icmp   = icmp;
      ip_broadcast = bc;
      ip_to_ip     = to;
      ip_remote_ip = rem;
      icmp_ready   = (i >= chg_at) ? ~ir : ir;
      udp_ready    = (i >= chg_at) ? ~ur : ur;
      data         = 8'(i + 1);
      if (i == 0) begin
        if (kind != 0) begin m_acc++; m_rem = rem; end
        else m_drp++;
      end
      pend_icmp = !blocked && kind == 1;
      pend_udp  = !blocked && kind == 2;
      pend_data = data;
      model_counts();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    #3;
    chk("reset_udp_en", {31'b0, udp_en}, 32'h0);
    chk("reset_data_out", {24'b0, dout}, 32'h0);
    chk("reset_drop", {16'b0, drp_cnt}, 32'h0);
    #4;
    rst_n = 1'b1;
    idle(1, 1'b0);
    chk_en = 1'b1;
    idle(3, 1'b0);

    // Unicast UDP, 8 bytes accepted
    idle(2, 1'b1);
    send_pkt(LOCAL, 32'h0A000001, 0, 0, 1, 1, 8, 99, 99, 99);
    idle(2, 1'b0);
    chk("A_accept", {16'b0, acc_cnt}, STATS ? 32'd1 : 32'd0);
    chk("A_remote", rip, 32'h0A000001);

    // ICMP to another host: dropped, remote unchanged
    idle(1, 1'b1);
    send_pkt(32'hC0A80163, 32'h0A000002, 1, 0, 1, 1, 4, 99, 99, 99);
    idle(2, 1'b0);
    chk("B_drop", {16'b0, drp_cnt}, STATS ? 32'd1 : 32'd0);
    chk("B_remote", rip, 32'h0A000001);

    // Broadcast UDP with sink busy at decision, ready rises mid-packet
    send_pkt(32'hFFFFFFFF, 32'h0A000009, 0, 1, 1, 0, 5, 2, 99, 99);
    idle(2, 1'b0);

    // ICMP accepted; ready falls after byte 2 of 6
    send_pkt(LOCAL, 32'h0A000003, 1, 0, 1, 1, 6, 2, 99, 99);
    idle(2, 1'b0);
    chk("D_remote", rip, 32'h0A000003);

    // UDP aborted after byte 3, then a normal packet
    send_pkt(LOCAL, 32'h0A000004, 0, 0, 1, 1, 6, 99, 3, 99);
    idle(2, 1'b0);
    send_pkt(32'hFFFFFFFF, 32'h0A000005, 1, 1, 1, 0, 3, 99, 99, 99);
    idle(2, 1'b0);

    // More drops to saturate the narrow counters
    send_pkt(32'h01020304, 32'h0A000006, 0, 0, 1, 1, 3, 99, 99, 99);
    idle(1, 1'b0);
    send_pkt(32'h01020305, 32'h0A000007, 1, 0, 0, 0, 2, 99, 99, 99);
    idle(2, 1'b0);
    chk("sat_drop_narrow", {30'b0, drp_s}, STATS ? 32'd3 : 32'd0);
    chk("sat_acc_narrow", {30'b0, acc_s}, STATS ? 32'd3 : 32'd0);
    chk("wide_drop", {16'b0, drp_cnt}, STATS ? 32'd4 : 32'd0);

    // Reset asserted mid-packet, released while payload still flowing
    send_pkt(LOCAL, 32'h0A000008, 0, 0, 1, 1, 6, 99, 99, 2);
    idle(2, 1'b0);
    send_pkt(LOCAL, 32'h0A00000A, 0, 0, 1, 1, 4, 99, 99, 99);
    idle(2, 1'b0);
    chk("post_rst_accept", {16'b0, acc_cnt}, STATS ? 32'd1 : 32'd0);
    chk("post_rst_remote", rip, 32'h0A00000A);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ip_rx_dispatch.md
IP_RX_DISPATCH -- requirements
Module: ip_rx_dispatch

Interface
REQ-001 Parameter CNT_W, default 16, width of the statistics counters.
REQ-002 clock  in  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 rx_enable  in  1  Ethernet frame in progress; low between frames.
REQ-005 data  in  8  received byte stream, one byte per clock while rx_enable.
REQ-006 ip_active  in  1  IP payload byte present on data (from IP header parser).
REQ-007 ip_is_icmp  in  1  1 = ICMP packet, 0 = UDP packet; stable while ip_active.
REQ-008 ip_broadcast  in  1  frame received on the broadcast MAC.
REQ-009 ip_to_ip  in  32  destination IP of the current packet; stable while ip_active.
REQ-010 ip_remote_ip  in  32  sender IP of the current packet; stable while ip_active.
REQ-011 local_ip  in  32  this board's IP address.
REQ-012 icmp_ready, udp_ready  in  1 each  sink can accept a whole new packet.
REQ-013 icmp_rx_enable, udp_rx_enable  out  1 each  payload byte valid for that sink.
REQ-014 data_out  out  8  registered payload byte.
REQ-015 remote_ip_out  out  32  sender IP latched at packet accept.
REQ-016 accept_count, drop_count  out  CNT_W each  packet statistics.

Function
REQ-017 FSM states: ST_IDLE, ST_ICMP, ST_UDP, ST_DROP; one-hot encoding.
REQ-018 ST_IDLE with ip_active=1 (cycle N): decide once; addr_ok = ip_broadcast | (ip_to_ip == local_ip).
REQ-019 Decision: addr_ok & ip_is_icmp & icmp_ready -> ST_ICMP; addr_ok & !ip_is_icmp & udp_ready -> ST_UDP; otherwise -> ST_DROP.
REQ-020 Latency fixed at 1: byte on data in cycle N appears on data_out with the matching rx_enable output in cycle N+1.
REQ-021 icmp_rx_enable = 1 in cycle N+1 only if state is ST_ICMP and ip_active was 1 in cycle N; same rule for udp_rx_enable with ST_UDP.
REQ-022 icmp_rx_enable and udp_rx_enable are never both 1.
REQ-023 ST_DROP: both rx_enable outputs stay 0 for every byte of the packet.
REQ-024 icmp_ready/udp_ready sampled only at the decision cycle; deassertion mid-packet does not truncate forwarding.
REQ-025 Any forwarding/drop state with ip_active=0 -> ST_IDLE next cycle; enables 0 in that cycle.
REQ-026 rx_enable=0 in any state -> ST_IDLE next cycle, outputs enables 0 (aborted frame).
REQ-027 remote_ip_out loads ip_remote_ip at the decision cycle only when the packet is accepted; otherwise holds its value.
REQ-028 accept_count increments once per ST_ICMP/ST_UDP entry; drop_count once per ST_DROP entry; both saturate at all-ones, no wrap.
REQ-029 data_out updates every cycle regardless of state; consumers qualify it with the enables.

Reset
REQ-030 rst_n low: state ST_IDLE, enables 0, data_out 0, remote_ip_out 0, counters 0; immediate, no clock needed.
REQ-031 Reset released mid-packet: stay in ST_IDLE until ip_active=0 is seen, then accept the next packet (no partial forwarding).

Configuration
REQ-032 Macro IP_RX_DISPATCH_STATS_EN defined: both counters implemented per REQ-028.
REQ-033 Macro undefined: counter logic is absent and accept_count/drop_count are tied to 0; all other behaviour is unchanged.

Structure
REQ-034 Shared package ip_rx_pkg holds the state encoding constants, the ICMP/UDP protocol numbers and the CNT_W default.
REQ-035 One sub-module sat_counter (enable, saturating, async active-low clear), instantiated twice.

Verification
REQ-036 Unicast UDP, to_ip=local_ip=192.168.1.10, udp_ready=1, 8 payload bytes 0x01..0x08 -> udp_rx_enable high 8 cycles starting N+1, data_out 0x01..0x08, accept_count=1.
REQ-037 ICMP with to_ip=192.168.1.99, broadcast=0 -> no enables, drop_count=1, remote_ip_out unchanged.
REQ-038 Broadcast UDP, udp_ready=0 at decision -> dropped; udp_ready rising mid-packet has no effect.
REQ-039 ICMP accepted, icmp_ready falls after byte 2 of 6 -> all 6 bytes forwarded.
REQ-040 rx_enable drops after byte 3 -> enable low next cycle, ST_IDLE; next packet accepted normally.
REQ-041 Counter preset near all-ones with stats enabled, 2 more drops -> drop_count holds 0xFFFF; stats disabled -> both counters read 0.
